// File: rtl/tow_referee.sv
// Round controller for the tug-of-war scorer: random dark delay, start light,
// first-push arbitration and release-before-rearm gating.
//
// state | meaning
// ------+---------------------------------------------------------
// REL   | wait until both buttons stay released, then arm a round
// DARK  | light off, random delay counting down; a push jumps the light
// LIT   | light on, waiting for the first push (optional timeout)
// HIT   | one-cycle winrnd pulse carrying right/tie/leds_on
// HALT  | game over; everything off until reset
module tow_referee #(
    parameter int unsigned DELAY_MIN   = 16,
    parameter int unsigned DELAY_BITS  = 8,
    parameter int unsigned RELEASE_CYC = 4,
    parameter int unsigned LIT_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_l,
    input  logic       pb_r,
    input  logic       game_over,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic       leds_on,
    output logic [2:0] state_dbg
);

    localparam int unsigned DW = $clog2(DELAY_MIN + (1 << DELAY_BITS));
    localparam int unsigned CW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam int unsigned TW = (LIT_TIMEOUT > 1) ? $clog2(LIT_TIMEOUT + 1) : 1;
    localparam bit          TMO_EN = (LIT_TIMEOUT != 0);

    typedef enum logic [2:0] {
        REL  = 3'd0,
        DARK = 3'd1,
        LIT  = 3'd2,
        HIT  = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [1:0]      sync_l, sync_r;
    logic            sl, sr, push;
    logic [15:0]     lfsr;
    logic [DW-1:0]   dly, dly_n, dly_seed;
    logic [CW-1:0]   cnt, cnt_n;
    logic [TW-1:0]   tmo, tmo_n;
    logic            winrnd_n, right_n, tie_n, leds_n;

    assign sl        = sync_l[1];
    assign sr        = sync_r[1];
    assign push      = sl | sr;
    assign dly_seed  = DW'(DELAY_MIN) + DW'(lfsr[DELAY_BITS-1:0]);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_l  <= '0;
            sync_r  <= '0;
            lfsr    <= 16'hACE1;
            state   <= REL;
            dly     <= '0;
            cnt     <= '0;
            tmo     <= '0;
            winrnd  <= 1'b0;
            right   <= 1'b0;
            tie     <= 1'b0;
            leds_on <= 1'b0;
        end else begin
            sync_l  <= {sync_l[0], pb_l};
            sync_r  <= {sync_r[0], pb_r};
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            state   <= state_n;
            dly     <= dly_n;
            cnt     <= cnt_n;
            tmo     <= tmo_n;
            winrnd  <= winrnd_n;
            right   <= right_n;
            tie     <= tie_n;
            leds_on <= leds_n;
        end
    end

    always_comb begin
        state_n  = state;
        dly_n    = dly;
        cnt_n    = '0;
        tmo_n    = tmo;
        winrnd_n = 1'b0;
        right_n  = 1'b0;
        tie_n    = 1'b0;
        leds_n   = 1'b0;
        case (state)
            REL: begin
                // game_over is only looked at here so a round in flight always finishes
                if (game_over) begin
                    state_n = HALT;
                end else if (push) begin
                    cnt_n = '0;
                end else if (cnt == CW'(RELEASE_CYC - 1)) begin
                    state_n = DARK;
                    dly_n   = dly_seed;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DARK: begin
                dly_n = dly - DW'(1);
                if (push) begin
                    state_n  = HIT;
                    winrnd_n = 1'b1;
                    right_n  = sr & ~sl;
                    tie_n    = sl & sr;
                end else if (dly == DW'(1)) begin
                    state_n = LIT;
                    leds_n  = 1'b1;
                    tmo_n   = TW'(LIT_TIMEOUT);
                end
            end
            LIT: begin
                leds_n = 1'b1;
                tmo_n  = tmo - TW'(1);
                if (push) begin
                    state_n  = HIT;
                    winrnd_n = 1'b1;
                    right_n  = sr & ~sl;
                    tie_n    = sl & sr;
                end else if (TMO_EN && tmo == TW'(1)) begin
                    state_n = DARK;
                    dly_n   = dly_seed;
                    leds_n  = 1'b0;
                end
            end
            HIT: begin
                state_n = REL;
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = REL;
            end
        endcase
    end

endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee: one instance without and one with a lit
// timeout; expected round results go through a scoreboard queue.
module tb_tow_referee;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (no timeout)
    logic       rst = 1'b1, pb_l = 1'b0, pb_r = 1'b0, game_over = 1'b0;
    logic       winrnd_m, right_m, tie_m, leds_m;
    logic [2:0] state_m;

    // timeout instance
    logic       rst_t = 1'b1, pb_lt = 1'b0, pb_rt = 1'b0, game_over_t = 1'b0;
    logic       winrnd_t, right_t, tie_t, leds_t;
    logic [2:0] state_t;

    tow_referee #(.DELAY_MIN(4), .DELAY_BITS(3), .RELEASE_CYC(3), .LIT_TIMEOUT(0)) u_dut (
        .clk(clk), .rst(rst), .pb_l(pb_l), .pb_r(pb_r), .game_over(game_over),
        .winrnd(winrnd_m), .right(right_m), .tie(tie_m), .leds_on(leds_m), .state_dbg(state_m)
    );

    tow_referee #(.DELAY_MIN(4), .DELAY_BITS(3), .RELEASE_CYC(3), .LIT_TIMEOUT(6)) u_tmo (
        .clk(clk), .rst(rst_t), .pb_l(pb_lt), .pb_r(pb_rt), .game_over(game_over_t),
        .winrnd(winrnd_t), .right(right_t), .tie(tie_t), .leds_on(leds_t), .state_dbg(state_t)
    );

    // reference LFSR models; prev holds the value the DUT used at the last edge
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [15:0] m_lfsr, m_prev, m2_lfsr, m2_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end
    always @(posedge clk or posedge rst_t) begin
        if (rst_t) begin
            m2_lfsr <= 16'hACE1;
            m2_prev <= 16'hACE1;
        end else begin
            m2_prev <= m2_lfsr;
            m2_lfsr <= lfsr_step(m2_lfsr);
        end
    end

    logic        sel = 1'b0;
    logic        win, rgt, tie_o, leds;
    logic [2:0]  st;
    logic [15:0] mprev;
    assign win   = sel ? winrnd_t : winrnd_m;
    assign rgt   = sel ? right_t  : right_m;
    assign tie_o = sel ? tie_t    : tie_m;
    assign leds  = sel ? leds_t   : leds_m;
    assign st    = sel ? state_t  : state_m;
    assign mprev = sel ? m2_prev  : m_prev;

    typedef struct {
        logic right;
        logic tie;
        logic leds;
        int   lat;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic r, input logic t, input logic l, input int lat);
        exp_t e;
        e.right = r;
        e.tie   = t;
        e.leds  = l;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] target, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit && n < 0; i++) begin
            @(negedge clk);
            if (st === target) n = i;
        end
    endtask

    task automatic wait_winrnd(input string tag);
        int   lat;
        exp_t e;
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (win === 1'b1) lat = i;
        end
        e = sb.pop_front();
        chk({tag, "_lat"},   lat,   e.lat);
        chk({tag, "_right"}, rgt,   e.right);
        chk({tag, "_tie"},   tie_o, e.tie);
        chk({tag, "_leds"},  leds,  e.leds);
    endtask

    // called on the first DARK cycle; returns on the first LIT cycle
    task automatic to_lit(input string tag);
        int          d;
        logic [15:0] seed;
        logic        quiet;
        seed  = mprev;
        d     = 0;
        quiet = 1'b1;
        while (st === 3'd1 && d < 40) begin
            if (leds !== 1'b0 || win !== 1'b0) quiet = 1'b0;
            d++;
            @(negedge clk);
        end
        chk({tag, "_dark_len"}, d, 4 + int'(seed[2:0]));
        chk({tag, "_dark_quiet"}, quiet, 1'b1);
        chk({tag, "_lit"}, {st, leds}, {3'd2, 1'b1});
    endtask

    task automatic lit_timeout(input string tag);
        int   d;
        logic quiet;
        d     = 0;
        quiet = 1'b1;
        while (st === 3'd2 && d < 40) begin
            if (leds !== 1'b1 || win !== 1'b0) quiet = 1'b0;
            d++;
            @(negedge clk);
        end
        chk({tag, "_len"}, d, 6);
        chk({tag, "_lit_clean"}, quiet, 1'b1);
        chk({tag, "_back_dark"}, {st, leds, win}, {3'd1, 1'b0, 1'b0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, pulses;
        logic ok;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {winrnd_m, right_m, tie_m, leds_m}, 4'b0000);
        chk("rst_state", state_m, 3'd0);
        rst = 1'b0;
        wait_state(3'd1, 20, n);
        chk("first_rel_len", n, 3);
        to_lit("first");

        // right press 5 cycles into LIT
        repeat (5) @(negedge clk);
        pb_r = 1'b1;
        push_exp(1'b1, 1'b0, 1'b1, 3);
        wait_winrnd("right_lit");
        @(negedge clk);
        chk("after_hit", {win, leds, st}, {1'b0, 1'b0, 3'd0});
        pb_r = 1'b0;

        // left jumps the light, then is held
        wait_state(3'd1, 20, n);
        chk("rearm_after_right", n, 5);
        pb_l = 1'b1;
        push_exp(1'b0, 1'b0, 1'b0, 3);
        wait_winrnd("left_dark");
        pulses = 0;
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (win) pulses++;
            if (st !== 3'd0 && st !== 3'd3) ok = 1'b0;
        end
        chk("held_no_pulse", pulses, 0);
        chk("held_stays_rel", ok, 1'b1);
        pb_l = 1'b0;
        wait_state(3'd1, 20, n);
        chk("rearm_after_hold", n, 5);
        to_lit("second");

        // simultaneous push in LIT
        pb_l = 1'b1;
        pb_r = 1'b1;
        push_exp(1'b0, 1'b1, 1'b1, 3);
        wait_winrnd("tie");
        pb_l = 1'b0;
        pb_r = 1'b0;
        wait_state(3'd1, 20, n);
        to_lit("third");

        // right one cycle behind left
        pb_l = 1'b1;
        push_exp(1'b0, 1'b0, 1'b1, 2);
        @(negedge clk);
        pb_r = 1'b1;
        wait_winrnd("skew");
        pb_l = 1'b0;
        pb_r = 1'b0;
        wait_state(3'd1, 20, n);
        to_lit("fourth");

        // game over raised in LIT: round completes, then HALT
        game_over = 1'b1;
        repeat (2) @(negedge clk);
        pb_l = 1'b1;
        push_exp(1'b0, 1'b0, 1'b1, 3);
        wait_winrnd("gameover_hit");
        @(negedge clk);
        chk("gameover_rel", st, 3'd0);
        @(negedge clk);
        chk("halt_entered", st, 3'd4);
        game_over = 1'b0;
        pulses = 0;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pb_l = i[2];
            pb_r = i[3];
            @(negedge clk);
            if (win || leds || rgt || tie_o) pulses++;
            if (st !== 3'd4) ok = 1'b0;
        end
        chk("halt_outputs_zero", pulses, 0);
        chk("halt_sticky", ok, 1'b1);
        pb_l = 1'b0;
        pb_r = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt_rst_state", st, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_state(3'd1, 20, n);
        chk("rel_after_halt", n, 3);
        to_lit("fifth");

        // reset while winrnd is high, button held through reset
        pb_r = 1'b1;
        push_exp(1'b1, 1'b0, 1'b1, 3);
        wait_winrnd("pre_abort");
        rst = 1'b1;
        #1;
        chk("rst_abort", {win, rgt, leds, st}, {1'b0, 1'b0, 1'b0, 3'd0});
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st !== 3'd0) ok = 1'b0;
        end
        chk("held_through_rst", ok, 1'b1);
        pb_r = 1'b0;
        wait_state(3'd1, 20, n);
        chk("rearm_after_rst_hold", n, 5);

        // timeout instance
        sel = 1'b1;
        rst_t = 1'b0;
        wait_state(3'd1, 20, n);
        chk("tmo_rel_len", n, 3);
        to_lit("tmo_a");
        lit_timeout("tmo_a");
        to_lit("tmo_b");
        lit_timeout("tmo_b");
        repeat (2) @(negedge clk);
        rst_t = 1'b1;
        #1;
        chk("tmo_rst_outputs", {win, rgt, tie_o, leds}, 4'b0000);
        chk("tmo_rst_state", st, 3'd0);
        chk("tmo_rst_lfsr", u_tmo.lfsr, 16'hACE1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
